tff_bank_ctrl: RTL and testbench

Command-driven sequencer for an N-bit bank of T flip-flops, held inside the block as the register `q`. It accepts clear, preset, toggle-mask and count commands over a valid/ready handshake. It then drives the bank's toggle enables and its preset/clear strobes cycle by cycle. It sits between a host/control FSM and any logic that consumes the bank state as a divider or counter value.

---
 rtl/tff_bank_ctrl.sv | 116 +++++++++++
 tb/tb_tff_bank_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_ctrl.sv
// rtl/tff_bank_ctrl.sv - command sequencer for an N-bit T flip-flop bank
// Accepts CLEAR/PRESET/COUNT/TOGGLE commands and drives the bank toggles and strobes.
module tff_bank_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_arg,
  output logic [N-1:0] t_en,
  output logic         pre_o,
  output logic         clr_o,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_COUNT  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic [1:0]   r_op;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_rem;
  logic [N-1:0] r_q;
  logic         r_armed;
  logic [N-1:0] w_cnt_ten;

  // Ripple-carry toggle chain: bit i toggles when every lower bit is one.
  always_comb begin
    logic v_carry;
    v_carry = 1'b1;
    for (int i = 0; i < N; i++) begin
      w_cnt_ten[i] = v_carry;
      v_carry      = v_carry & r_q[i];
    end
  end

  always_comb begin
    t_en  = '0;
    pre_o = 1'b0;
    clr_o = 1'b0;
    case (r_state)
      S_APPLY: begin
        case (r_op)
          OP_CLEAR:  clr_o = 1'b1;
          OP_PRESET: pre_o = 1'b1;
          OP_TOGGLE: t_en  = r_mask;
          default:   ;
        endcase
      end
      S_COUNT: t_en = w_cnt_ten;
      default: ;
    endcase
  end

  // r_armed keeps cmd_ready low until the first clock edge after reset release.
  assign cmd_ready = (r_state == S_IDLE) && r_armed;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign q         = r_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_CLEAR;
      r_mask  <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op   <= cmd_op;
            r_mask <= cmd_arg;
            if (cmd_op == OP_COUNT) begin
              r_rem   <= cmd_arg;
              r_state <= (cmd_arg == '0) ? S_DONE : S_COUNT;
            end else begin
              r_state <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          case (r_op)
            OP_CLEAR:  r_q <= '0;
            OP_PRESET: r_q <= '1;
            OP_TOGGLE: r_q <= r_q ^ r_mask;
            default:   ;
          endcase
          r_state <= S_DONE;
        end
        S_COUNT: begin
          r_q   <= r_q ^ w_cnt_ten;
          r_rem <= r_rem - N'(1);
          if (r_rem == N'(1)) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_bank_ctrl.sv
// tb/tb_tff_bank_ctrl.sv - self-checking bench for tff_bank_ctrl (N=4)
// A per-command expected-output trace is compared against the DUT on every falling edge.
module tb_tff_bank_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_arg;
  logic [N-1:0] t_en;
  logic         pre_o;
  logic         clr_o;
  logic [N-1:0] q;
  logic         busy;
  logic         done;

  tff_bank_ctrl #(.N(N)) dut (
    .clk(clk), .clr_n(clr_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .t_en(t_en), .pre_o(pre_o),
    .clr_o(clr_o), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] t_en;
    logic         pre;
    logic         clr;
    logic         done;
    logic [N-1:0] q;
  } exp_t;

  exp_t         q_exp[$];
  logic [N-1:0] model_q = '0;
  logic         exp_armed = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (clr_n) exp_armed = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (!clr_n) begin
      chk("rst_t_en", int'(t_en), 0);
      chk("rst_strobes", int'({pre_o, clr_o, done, busy, cmd_ready}), 0);
      chk("rst_q", int'(q), 0);
    end else if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      chk("t_en", int'(t_en), int'(e.t_en));
      chk("pre_o", int'(pre_o), int'(e.pre));
      chk("clr_o", int'(clr_o), int'(e.clr));
      chk("done", int'(done), int'(e.done));
      chk("busy", int'(busy), 1);
      chk("cmd_ready_busy", int'(cmd_ready), 0);
      chk("q", int'(q), int'(e.q));
    end else begin
      chk("idle_t_en", int'(t_en), 0);
      chk("idle_strobes", int'({pre_o, clr_o, done, busy}), 0);
      chk("idle_ready", int'(cmd_ready), int'(exp_armed));
      chk("idle_q", int'(q), int'(model_q));
    end
  end

  // Expected cycles from accept edge E0 until the DONE cycle, built from the command's meaning.
  task automatic push_trace(input logic [1:0] op, input logic [N-1:0] arg);
    case (op)
      2'b00: begin q_exp.push_back('{'0, 1'b0, 1'b1, 1'b0, model_q}); model_q = '0; end
      2'b01: begin q_exp.push_back('{'0, 1'b1, 1'b0, 1'b0, model_q}); model_q = '1; end
      2'b11: begin q_exp.push_back('{arg, 1'b0, 1'b0, 1'b0, model_q}); model_q = model_q ^ arg; end
      default: begin
        for (int i = 0; i < int'(arg); i++) begin
          q_exp.push_back('{model_q ^ (model_q + 4'd1), 1'b0, 1'b0, 1'b0, model_q});
          model_q = model_q + 4'd1;
        end
      end
    endcase
    q_exp.push_back('{'0, 1'b0, 1'b0, 1'b1, model_q});
  endtask

  // Called between a falling and a rising edge; returns on the falling edge after acceptance.
  task automatic send(input logic [1:0] op, input logic [N-1:0] arg);
    logic rdy;
    bit   ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    for (int i = 0; i < 60 && !ok; i++) begin
      rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        push_trace(op, arg);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cmd_op    = $urandom_range(0, 3);
    cmd_arg   = $urandom_range(0, 15);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (q_exp.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  logic [N-1:0] ten_k5 [5];

  initial begin
    ten_k5 = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001};
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    clr_n     = 1'b1;
    #1 clr_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lit_rst_ready", int'(cmd_ready), 0);
    #2 clr_n = 1'b1;
    @(negedge clk);
    chk("lit_ready_after_release", int'(cmd_ready), 1);

    send(2'b01, '0);
    chk("lit_preset_strobe", int'(pre_o), 1);
    wait_idle();
    chk("lit_preset_q", int'(q), 15);
    send(2'b11, 4'b0101);
    chk("lit_toggle_ten", int'(t_en), 5);
    wait_idle();
    chk("lit_toggle_q", int'(q), 10);

    send(2'b00, '0);
    send(2'b10, 4'd5);
    for (int i = 0; i < 5; i++) begin
      chk("lit_k5_ten", int'(t_en), int'(ten_k5[i]));
      @(negedge clk);
    end
    chk("lit_k5_done", int'(done), 1);
    wait_idle();
    chk("lit_k5_q", int'(q), 5);

    send(2'b01, '0);
    send(2'b11, 4'b0001);
    wait_idle();
    chk("lit_q_1110", int'(q), 14);
    send(2'b10, 4'd3);
    @(negedge clk);
    chk("lit_wrap_ten", int'(t_en), 15);
    wait_idle();
    chk("lit_wrap_q", int'(q), 1);

    send(2'b10, 4'd0);
    chk("lit_k0_done", int'(done), 1);
    chk("lit_k0_ten", int'(t_en), 0);
    send(2'b10, 4'd15);
    send(2'b11, 4'b0011);
    wait_idle();
    chk("lit_k15_toggle_q", int'(q), 3);

    send(2'b10, 4'd10);
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    q_exp.delete();
    model_q   = '0;
    exp_armed = 1'b0;
    #1;
    chk("lit_abort_q", int'(q), 0);
    chk("lit_abort_busy", int'(busy), 0);
    chk("lit_abort_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    #2 clr_n = 1'b1;
    send(2'b00, '0);
    wait_idle();
    chk("lit_clear_after_abort", int'(q), 0);

    send(2'b11, 4'b1001);
    send(2'b10, 4'd7);
    wait_idle();
    chk("lit_final_q", int'(q), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
